// File: rtl/edge_bram_arbiter.sv
// Shares the single-port edge/bin BRAM between display scan-out (P0), contour tracer (P1) and edge writer (P2).
// Optional build macro ARB_STATS_EN adds saturating acceptance/stall counters with a synchronous clear.
module edge_bram_arbiter #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int AW     = 19,
    parameter int DW     = 3,
    parameter int RD_LAT = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0]      req,
    input  logic [2:0]      we,
    input  logic [3*AW-1:0] addr,
    input  logic [3*DW-1:0] wdata,
    input  logic [2:0]      lock,
    output logic [2:0]      gnt,
    output logic [2:0]      rvalid,
    output logic [DW-1:0]   rdata,
    output logic            oob_err,
    output logic [AW-1:0]   bram_addr,
    output logic            bram_we,
    output logic [DW-1:0]   bram_din,
    input  logic [DW-1:0]   bram_dout
`ifdef ARB_STATS_EN
    ,
    input  logic            stat_clr,
    output logic [15:0]     stat_gnt0,
    output logic [15:0]     stat_gnt1,
    output logic [15:0]     stat_gnt2,
    output logic [15:0]     stat_stall
`endif
);
    localparam logic [AW-1:0] FRAME_PIX = AW'(WIDTH * HEIGHT);

    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_P1, OWN_P2} owner_t;
    typedef struct packed {
        logic       valid;
        logic       oob;
        logic [1:0] id;
    } ret_t;

    state_t        state_q;
    owner_t        owner_q;
    logic          rr_q;       // 0: P1 wins next P1/P2 tie, 1: P2 wins
    logic [3:0]    lock_cnt_q;
    logic [2:0]    win;
    logic          acc;
    logic [1:0]    acc_id;
    logic          sel_we;
    logic          sel_lock;
    logic          sel_oob;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          own_req;
    logic          own_lock;

    ret_t          ret_q [0:RD_LAT];
    logic [AW-1:0] bram_addr_q;
    logic          bram_we_q;
    logic [DW-1:0] bram_din_q;
    logic          oob_q;

    always_comb begin
        own_req  = 1'b0;
        own_lock = 1'b0;
        if (owner_q == OWN_P1) begin
            own_req  = req[1];
            own_lock = lock[1];
        end else if (owner_q == OWN_P2) begin
            own_req  = req[2];
            own_lock = lock[2];
        end
    end

    // NOTE: every always_comb output is given a default first so no path leaves it unassigned (no latch).
    always_comb begin
        win = 3'b000;
        if (state_q == ST_LOCKED) begin
            win[1] = (owner_q == OWN_P1) && req[1];
            win[2] = (owner_q == OWN_P2) && req[2];
        end else if (req[0]) begin
            win = 3'b001;
        end else if (req[1] && req[2]) begin
            win = rr_q ? 3'b100 : 3'b010;
        end else if (req[1]) begin
            win = 3'b010;
        end else if (req[2]) begin
            win = 3'b100;
        end
    end

    assign gnt = rst ? 3'b000 : win;
    assign acc = |gnt;

    always_comb begin
        acc_id    = 2'd0;
        sel_addr  = addr[0 +: AW];
        sel_wdata = wdata[0 +: DW];
        sel_we    = 1'b0;
        sel_lock  = 1'b0;
        if (gnt[1]) begin
            acc_id    = 2'd1;
            sel_addr  = addr[AW +: AW];
            sel_wdata = wdata[DW +: DW];
            sel_we    = we[1];
            sel_lock  = lock[1];
        end else if (gnt[2]) begin
            acc_id    = 2'd2;
            sel_addr  = addr[2*AW +: AW];
            sel_wdata = wdata[2*DW +: DW];
            sel_we    = we[2];
            sel_lock  = lock[2];
        end
    end

    // Unsigned compare also catches addresses that underflowed below zero.
    assign sel_oob = (sel_addr >= FRAME_PIX);

    // NOTE: sequential state is written only with non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_NONE;
            rr_q       <= 1'b0;
            lock_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (acc && acc_id != 2'd0) begin
                        rr_q <= (acc_id == 2'd1);
                        if (sel_lock) begin
                            state_q    <= ST_LOCKED;
                            owner_q    <= (acc_id == 2'd1) ? OWN_P1 : OWN_P2;
                            lock_cnt_q <= '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (!own_lock) begin
                        state_q    <= ST_IDLE;
                        owner_q    <= OWN_NONE;
                        lock_cnt_q <= '0;
                    end else if (own_req) begin
                        lock_cnt_q <= '0;
                    end else if (lock_cnt_q == 4'hF) begin
                        state_q    <= ST_IDLE;
                        owner_q    <= OWN_NONE;
                        lock_cnt_q <= '0;
                    end else begin
                        lock_cnt_q <= lock_cnt_q + 4'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // NOTE: the return pipeline is reset (unlike a data array) so reads in flight vanish on rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bram_addr_q <= '0;
            bram_we_q   <= 1'b0;
            bram_din_q  <= '0;
            oob_q       <= 1'b0;
            for (int i = 0; i <= RD_LAT; i++) ret_q[i] <= '0;
        end else begin
            bram_we_q <= acc && sel_we && !sel_oob;
            oob_q     <= acc && sel_oob;
            if (acc) begin
                bram_addr_q <= sel_oob ? '0 : sel_addr;
                bram_din_q  <= sel_wdata;
            end
            ret_q[0] <= '{valid: acc && !sel_we, oob: sel_oob, id: acc_id};
            for (int i = 1; i <= RD_LAT; i++) ret_q[i] <= ret_q[i-1];
        end
    end

    assign bram_addr = bram_addr_q;
    assign bram_we   = bram_we_q;
    assign bram_din  = bram_din_q;
    assign oob_err   = oob_q;

    always_comb begin
        rvalid = 3'b000;
        rdata  = '0;
        if (ret_q[RD_LAT].valid) begin
            rvalid[ret_q[RD_LAT].id] = 1'b1;
            if (!ret_q[RD_LAT].oob) rdata = bram_dout;
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] stat_gnt_q [0:2];
    logic [15:0] stat_stall_q;
    logic        stall;

    assign stall = |(req & ~gnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) stat_gnt_q[i] <= '0;
            stat_stall_q <= '0;
        end else if (stat_clr) begin
            for (int i = 0; i < 3; i++) stat_gnt_q[i] <= '0;
            stat_stall_q <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (gnt[i] && stat_gnt_q[i] != 16'hFFFF) stat_gnt_q[i] <= stat_gnt_q[i] + 16'd1;
            end
            if (stall && stat_stall_q != 16'hFFFF) stat_stall_q <= stat_stall_q + 16'd1;
        end
    end

    assign stat_gnt0  = stat_gnt_q[0];
    assign stat_gnt1  = stat_gnt_q[1];
    assign stat_gnt2  = stat_gnt_q[2];
    assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_edge_bram_arbiter.sv
// Directed self-checking bench for edge_bram_arbiter with a behavioural RD_LAT=2 BRAM model.
module tb_edge_bram_arbiter;
    localparam int AW = 19;
    localparam int DW = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [2:0]      req = '0;
    logic [2:0]      we = '0;
    logic [2:0]      lock = '0;
    logic [AW-1:0]   a0 = '0, a1 = '0, a2 = '0;
    logic [DW-1:0]   wd0 = '0, wd1 = '0, wd2 = '0;
    logic [3*AW-1:0] addr;
    logic [3*DW-1:0] wdata;
    logic [2:0]      gnt, rvalid;
    logic [DW-1:0]   rdata, bram_din;
    logic            oob_err, bram_we;
    logic [AW-1:0]   bram_addr;
    logic [DW-1:0]   d1 = '0, bram_dout = '0;
    logic [DW-1:0]   mem [0:(1<<AW)-1];
    int              checks = 0;
    int              failures = 0;
`ifdef ARB_STATS_EN
    logic            stat_clr = 1'b0;
    logic [15:0]     stat_gnt0, stat_gnt1, stat_gnt2, stat_stall;
`endif

    assign addr  = {a2, a1, a0};
    assign wdata = {wd2, wd1, wd0};

    edge_bram_arbiter dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .lock(lock),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .oob_err(oob_err),
        .bram_addr(bram_addr), .bram_we(bram_we), .bram_din(bram_din), .bram_dout(bram_dout)
`ifdef ARB_STATS_EN
        , .stat_clr(stat_clr), .stat_gnt0(stat_gnt0), .stat_gnt1(stat_gnt1),
        .stat_gnt2(stat_gnt2), .stat_stall(stat_stall)
`endif
    );

    always #5 clk = ~clk;

    // Single-port BRAM, two-cycle read latency from bram_addr.
    always @(posedge clk) begin
        if (bram_we) mem[bram_addr] <= bram_din;
        d1        <= mem[bram_addr];
        bram_dout <= d1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 3'b111; lock = 3'b110; a0 = 19'd5;
        @(posedge clk); #1; @(posedge clk); #3;
        checks++; if (gnt !== 3'b000) begin failures++; $display("FAIL reset_gnt got=%b exp=000", gnt); end
        checks++; if (rvalid !== 3'b000) begin failures++; $display("FAIL reset_rvalid got=%b exp=000", rvalid); end
        checks++; if (rdata !== 3'd0) begin failures++; $display("FAIL reset_rdata got=%0d exp=0", rdata); end
        checks++; if (oob_err !== 1'b0) begin failures++; $display("FAIL reset_oob got=%b exp=0", oob_err); end
        checks++; if (bram_addr !== 19'd0) begin failures++; $display("FAIL reset_bram_addr got=%0d exp=0", bram_addr); end
        checks++; if (bram_we !== 1'b0) begin failures++; $display("FAIL reset_bram_we got=%b exp=0", bram_we); end
        checks++; if (bram_din !== 3'd0) begin failures++; $display("FAIL reset_bram_din got=%0d exp=0", bram_din); end
        req = 3'b000; lock = 3'b000; a0 = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_priority();
        a0 = 19'd10; a1 = 19'd11; a2 = 19'd12; we = 3'b000;
        req = 3'b111; #2;
        checks++; if (gnt !== 3'b001) begin failures++; $display("FAIL prio_gnt_all got=%b exp=001", gnt); end
        tick(); req = 3'b110; #2;
        checks++; if (gnt !== 3'b010) begin failures++; $display("FAIL prio_gnt_p1 got=%b exp=010", gnt); end
        tick(); req = 3'b100; #2;
        checks++; if (gnt !== 3'b100) begin failures++; $display("FAIL prio_gnt_p2 got=%b exp=100", gnt); end
        tick(); req = 3'b000; #2;
        checks++; if (rvalid !== 3'b001 || rdata !== 3'd1) begin failures++; $display("FAIL prio_ret0 got=%b/%0d exp=001/1", rvalid, rdata); end
        tick(); #2;
        checks++; if (rvalid !== 3'b010 || rdata !== 3'd2) begin failures++; $display("FAIL prio_ret1 got=%b/%0d exp=010/2", rvalid, rdata); end
        tick(); #2;
        checks++; if (rvalid !== 3'b100 || rdata !== 3'd4) begin failures++; $display("FAIL prio_ret2 got=%b/%0d exp=100/4", rvalid, rdata); end
        tick(); #2;
        checks++; if (rvalid !== 3'b000) begin failures++; $display("FAIL prio_ret_idle got=%b exp=000", rvalid); end
        tick();
    endtask

    task automatic test_single_read();
        a1 = 19'd100; we = 3'b000; req = 3'b010; #2;
        checks++; if (gnt !== 3'b010) begin failures++; $display("FAIL single_gnt got=%b exp=010", gnt); end
        tick(); req = 3'b000; #2;
        checks++; if (bram_addr !== 19'd100) begin failures++; $display("FAIL single_bram_addr got=%0d exp=100", bram_addr); end
        checks++; if (bram_we !== 1'b0) begin failures++; $display("FAIL single_bram_we got=%b exp=0", bram_we); end
        checks++; if (rvalid !== 3'b000) begin failures++; $display("FAIL single_early_rv_t1 got=%b exp=000", rvalid); end
        tick(); #2;
        checks++; if (rvalid !== 3'b000) begin failures++; $display("FAIL single_early_rv_t2 got=%b exp=000", rvalid); end
        tick(); #2;
        checks++; if (rvalid !== 3'b010) begin failures++; $display("FAIL single_rvalid got=%b exp=010", rvalid); end
        checks++; if (rdata !== 3'd5) begin failures++; $display("FAIL single_rdata got=%0d exp=5", rdata); end
        tick(); #2;
        checks++; if (rvalid !== 3'b000) begin failures++; $display("FAIL single_rv_after got=%b exp=000", rvalid); end
        tick();
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_rv [0:15];
        logic [2:0] exp_rd [0:15];
        logic [2:0] exp_g;
        int n1 = 0;
        int n2 = 0;
        for (int i = 0; i < 16; i++) begin exp_rv[i] = '0; exp_rd[i] = '0; end
        a1 = 19'd200; a2 = 19'd300; we = 3'b000;
        // The preceding lone P1 read left the pointer on P2.
        for (int c = 0; c < 14; c++) begin
            req = (c < 10) ? 3'b110 : 3'b000;
            #2;
            if (c < 10) begin
                exp_g = (c % 2 == 0) ? 3'b100 : 3'b010;
                checks++; if (gnt !== exp_g) begin failures++; $display("FAIL rr_gnt_c%0d got=%b exp=%b", c, gnt, exp_g); end
                if (gnt === 3'b010) n1++;
                if (gnt === 3'b100) n2++;
                exp_rv[c+3] = exp_g;
                exp_rd[c+3] = (exp_g == 3'b010) ? 3'd3 : 3'd6;
            end
            checks++; if (rvalid !== exp_rv[c]) begin failures++; $display("FAIL rr_rvalid_c%0d got=%b exp=%b", c, rvalid, exp_rv[c]); end
            if (exp_rv[c] != 3'b000) begin
                checks++; if (rdata !== exp_rd[c]) begin failures++; $display("FAIL rr_rdata_c%0d got=%0d exp=%0d", c, rdata, exp_rd[c]); end
            end
            tick();
        end
        checks++; if (n1 != 5 || n2 != 5) begin failures++; $display("FAIL rr_counts got=%0d/%0d exp=5/5", n1, n2); end
    endtask

    task automatic test_lock();
        a0 = 19'd0; a1 = 19'd640; we = 3'b000;
        req = 3'b010; lock = 3'b010; #2;
        checks++; if (gnt !== 3'b010) begin failures++; $display("FAIL lock_gnt_first got=%b exp=010", gnt); end
        tick(); req = 3'b011; we = 3'b010; wd1 = 3'd2; #2;
        checks++; if (gnt !== 3'b010) begin failures++; $display("FAIL lock_gnt_owner got=%b exp=010", gnt); end
        tick(); req = 3'b001; we = 3'b000; #2;
        checks++; if (gnt !== 3'b000) begin failures++; $display("FAIL lock_p0_blocked got=%b exp=000", gnt); end
        checks++; if (bram_we !== 1'b1 || bram_addr !== 19'd640 || bram_din !== 3'd2) begin
            failures++; $display("FAIL lock_write got=%b/%0d/%0d exp=1/640/2", bram_we, bram_addr, bram_din); end
        tick(); lock = 3'b000; #2;
        checks++; if (gnt !== 3'b000) begin failures++; $display("FAIL lock_p0_still_blocked got=%b exp=000", gnt); end
        checks++; if (rvalid !== 3'b010 || rdata !== 3'd7) begin failures++; $display("FAIL lock_read got=%b/%0d exp=010/7", rvalid, rdata); end
        tick(); #2;
        checks++; if (gnt !== 3'b001) begin failures++; $display("FAIL lock_p0_released got=%b exp=001", gnt); end
        tick(); req = 3'b000; #2;
        checks++; if (mem[640] !== 3'd2) begin failures++; $display("FAIL lock_mem640 got=%0d exp=2", mem[640]); end
        tick(); tick(); #2;
        checks++; if (rvalid !== 3'b001 || rdata !== 3'd0) begin failures++; $display("FAIL lock_p0_ret got=%b/%0d exp=001/0", rvalid, rdata); end
        tick();
    endtask

    task automatic test_lock_timeout();
        a0 = 19'd0; a2 = 19'd50; we = 3'b000;
        req = 3'b100; lock = 3'b100; #2;
        checks++; if (gnt !== 3'b100) begin failures++; $display("FAIL tmo_gnt_first got=%b exp=100", gnt); end
        tick();
        for (int c = 1; c <= 16; c++) begin
            req = 3'b001; #2;
            checks++; if (gnt !== 3'b000) begin failures++; $display("FAIL tmo_blocked_c%0d got=%b exp=000", c, gnt); end
            tick();
        end
        lock = 3'b000; #2;
        checks++; if (gnt !== 3'b001) begin failures++; $display("FAIL tmo_released got=%b exp=001", gnt); end
        tick(); req = 3'b000;
        tick(); tick(); tick();
    endtask

    task automatic test_oob();
        mem[0] = 3'd6;
        a1 = 19'h7FFFF; we = 3'b000; req = 3'b010; #2;
        checks++; if (gnt !== 3'b010) begin failures++; $display("FAIL oob_rd_gnt got=%b exp=010", gnt); end
        tick(); req = 3'b000; #2;
        checks++; if (oob_err !== 1'b1) begin failures++; $display("FAIL oob_rd_pulse got=%b exp=1", oob_err); end
        checks++; if (bram_addr !== 19'd0 || bram_we !== 1'b0) begin failures++; $display("FAIL oob_rd_bram got=%0d/%b exp=0/0", bram_addr, bram_we); end
        tick(); #2;
        checks++; if (oob_err !== 1'b0) begin failures++; $display("FAIL oob_rd_pulse_end got=%b exp=0", oob_err); end
        tick(); #2;
        checks++; if (rvalid !== 3'b010 || rdata !== 3'd0) begin failures++; $display("FAIL oob_rd_ret got=%b/%0d exp=010/0", rvalid, rdata); end
        tick(); a2 = 19'd307200; we = 3'b100; wd2 = 3'd7; req = 3'b100; #2;
        checks++; if (gnt !== 3'b100) begin failures++; $display("FAIL oob_wr_gnt got=%b exp=100", gnt); end
        tick(); req = 3'b000; we = 3'b000; #2;
        checks++; if (bram_we !== 1'b0 || oob_err !== 1'b1 || bram_addr !== 19'd0) begin
            failures++; $display("FAIL oob_wr_blocked got=%b/%b/%0d exp=0/1/0", bram_we, oob_err, bram_addr); end
        tick(); a2 = 19'd307199; we = 3'b100; wd2 = 3'd5; req = 3'b100; #2;
        checks++; if (gnt !== 3'b100) begin failures++; $display("FAIL edge_wr_gnt got=%b exp=100", gnt); end
        tick(); req = 3'b000; we = 3'b000; #2;
        checks++; if (bram_we !== 1'b1 || oob_err !== 1'b0 || bram_addr !== 19'd307199) begin
            failures++; $display("FAIL edge_wr_issued got=%b/%b/%0d exp=1/0/307199", bram_we, oob_err, bram_addr); end
        checks++; if (rvalid !== 3'b000) begin failures++; $display("FAIL oob_wr_no_strobe got=%b exp=000", rvalid); end
        tick(); tick(); #2;
        checks++; if (rvalid !== 3'b000) begin failures++; $display("FAIL edge_wr_no_strobe got=%b exp=000", rvalid); end
        checks++; if (mem[0] !== 3'd6 || mem[307199] !== 3'd5) begin
            failures++; $display("FAIL oob_mem got=%0d/%0d exp=6/5", mem[0], mem[307199]); end
        tick();
    endtask

    task automatic test_back_to_back_reset();
        we = 3'b000; a1 = 19'd20; req = 3'b010; #2;
        checks++; if (gnt !== 3'b010) begin failures++; $display("FAIL b2b_gnt0 got=%b exp=010", gnt); end
        tick(); a1 = 19'd21; #2;
        checks++; if (gnt !== 3'b010) begin failures++; $display("FAIL b2b_gnt1 got=%b exp=010", gnt); end
        tick(); a1 = 19'd22; rst = 1'b1; #2;
        checks++; if (gnt !== 3'b000 || bram_addr !== 19'd0) begin failures++; $display("FAIL b2b_rst_state got=%b/%0d exp=000/0", gnt, bram_addr); end
        checks++; if (rvalid !== 3'b000) begin failures++; $display("FAIL b2b_rv_rst got=%b exp=000", rvalid); end
        tick(); req = 3'b000; #2;
        checks++; if (rvalid !== 3'b000) begin failures++; $display("FAIL b2b_rv_c3 got=%b exp=000", rvalid); end
        tick(); rst = 1'b0; #2;
        checks++; if (rvalid !== 3'b000) begin failures++; $display("FAIL b2b_rv_c4 got=%b exp=000", rvalid); end
        tick(); #2;
        checks++; if (rvalid !== 3'b000) begin failures++; $display("FAIL b2b_rv_c5 got=%b exp=000", rvalid); end
        tick(); a1 = 19'd30; req = 3'b010; #2;
        checks++; if (gnt !== 3'b010) begin failures++; $display("FAIL b2b_post_gnt got=%b exp=010", gnt); end
        tick(); req = 3'b000;
        tick(); tick(); #2;
        checks++; if (rvalid !== 3'b010 || rdata !== 3'd4) begin failures++; $display("FAIL b2b_post_ret got=%b/%0d exp=010/4", rvalid, rdata); end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        mem[10] = 3'd1; mem[11] = 3'd2; mem[12] = 3'd4;
        mem[100] = 3'b101; mem[200] = 3'd3; mem[300] = 3'd6; mem[640] = 3'd7;
        mem[20] = 3'd1; mem[21] = 3'd2; mem[22] = 3'd3; mem[30] = 3'd4;
        test_reset();
        test_priority();
        test_single_read();
        test_round_robin();
        test_lock();
        test_lock_timeout();
        test_oob();
        test_back_to_back_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
